// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the start/stop TDC channel pair: coarse period count plus fine codes.
// Define TDC_MEAS_STATS_EN to add the meas_cnt / timeout_cnt statistics outputs.
module tdc_meas_ctrl #(
  parameter int unsigned COARSE_W    = 10,
  parameter int unsigned FINE_W      = 5,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic                       start_valid,
  input  logic                       stop_valid,
  input  logic [FINE_W-1:0]          fine_start,
  input  logic [FINE_W-1:0]          fine_stop,
  input  logic                       res_ready,
  output logic                       res_valid,
  output logic [COARSE_W+FINE_W-1:0] res_data,
  output logic                       res_timeout,
  output logic                       res_neg,
  output logic                       busy,
`ifdef TDC_MEAS_STATS_EN
  output logic [15:0]                meas_cnt,
  output logic [7:0]                 timeout_cnt,
`endif
  output logic [COARSE_W-1:0]        coarse_cnt
);

  localparam int unsigned DataW = COARSE_W + FINE_W;
  localparam int unsigned DiffW = DataW + 1;
  localparam logic [COARSE_W-1:0] TimeoutCnt = COARSE_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StCount,
    StCalc,
    StOut
  } state_e;

  state_e              state_q, state_d;
  logic [COARSE_W-1:0] cnt_q, cnt_d;
  logic [FINE_W-1:0]   fine_start_q, fine_start_d;
  logic [FINE_W-1:0]   fine_stop_q, fine_stop_d;
  logic [DataW-1:0]    res_data_q, res_data_d;
  logic                res_timeout_q, res_timeout_d;
  logic                res_neg_q, res_neg_d;
  logic [DiffW-1:0]    diff;
  logic                handshake;

  // Two's complement interval with one guard bit; the MSB is the sign.
  assign diff = {1'b0, cnt_q, {FINE_W{1'b0}}}
              + {{(DiffW-FINE_W){1'b0}}, fine_start_q}
              - {{(DiffW-FINE_W){1'b0}}, fine_stop_q};

  assign handshake = (state_q == StOut) && res_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fine_start_d  = fine_start_q;
    fine_stop_d   = fine_stop_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    res_neg_d     = res_neg_q;

    case (state_q)
      StIdle: begin
        if (arm) begin
          state_d = StArmed;
        end
      end

      StArmed: begin
        if (!arm) begin
          state_d = StIdle;
        end else if (start_valid) begin
          // A stop in the same cycle as the start is deliberately ignored.
          fine_start_d = fine_start;
          cnt_d        = '0;
          state_d      = StCount;
        end
      end

      StCount: begin
        if (stop_valid) begin
          // Stop beats a simultaneous timeout; the count freezes at this cycle's value.
          fine_stop_d = fine_stop;
          state_d     = StCalc;
        end else if (cnt_q == TimeoutCnt) begin
          res_data_d    = '1;
          res_timeout_d = 1'b1;
          res_neg_d     = 1'b0;
          state_d       = StOut;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StCalc: begin
        res_timeout_d = 1'b0;
        if (diff[DiffW-1]) begin
          res_data_d = '0;
          res_neg_d  = 1'b1;
        end else begin
          res_data_d = diff[DataW-1:0];
          res_neg_d  = 1'b0;
        end
        state_d = StOut;
      end

      StOut: begin
        if (res_ready) begin
          res_timeout_d = 1'b0;
          res_neg_d     = 1'b0;
          state_d       = arm ? StArmed : StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      fine_start_q  <= '0;
      fine_stop_q   <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      res_neg_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fine_start_q  <= fine_start_d;
      fine_stop_q   <= fine_stop_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      res_neg_q     <= res_neg_d;
    end
  end

  assign res_valid   = (state_q == StOut);
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign res_neg     = res_neg_q;
  assign busy        = (state_q != StIdle);
  assign coarse_cnt  = cnt_q;

`ifdef TDC_MEAS_STATS_EN
  logic [15:0] meas_cnt_q;
  logic [7:0]  timeout_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else if (handshake) begin
      if (res_timeout_q) begin
        timeout_cnt_q <= timeout_cnt_q + 1'b1;
      end else begin
        meas_cnt_q <= meas_cnt_q + 1'b1;
      end
    end
  end

  assign meas_cnt    = meas_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl: directed scenarios plus randomized measurements
// checked against a transaction-level interval model.
module tb_tdc_meas_ctrl;

  localparam int COARSE_W    = 10;
  localparam int FINE_W      = 5;
  localparam int TIMEOUT_CYC = 1000;
  localparam int DW          = COARSE_W + FINE_W;

  logic                clk;
  logic                rst_n;
  logic                arm;
  logic                start_valid;
  logic                stop_valid;
  logic [FINE_W-1:0]   fine_start;
  logic [FINE_W-1:0]   fine_stop;
  logic                res_ready;
  logic                res_valid;
  logic [DW-1:0]       res_data;
  logic                res_timeout;
  logic                res_neg;
  logic                busy;
  logic [COARSE_W-1:0] coarse_cnt;
`ifdef TDC_MEAS_STATS_EN
  logic [15:0]         meas_cnt;
  logic [7:0]          timeout_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Observations from the last run_meas call.
  int            obs_lat;
  int            obs_cnt;
  int            obs_unstable;
  logic [DW-1:0] obs_data;
  logic          obs_tmo;
  logic          obs_neg;
  logic          obs_valid_after;
  logic          obs_flags_after;
  logic          obs_busy_after;
  bit            armed_now;
  int            exp_meas;
  int            exp_tmo;

  tdc_meas_ctrl #(
    .COARSE_W   (COARSE_W),
    .FINE_W     (FINE_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .start_valid(start_valid),
    .stop_valid (stop_valid),
    .fine_start (fine_start),
    .fine_stop  (fine_stop),
    .res_ready  (res_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_timeout(res_timeout),
    .res_neg    (res_neg),
    .busy       (busy),
`ifdef TDC_MEAS_STATS_EN
    .meas_cnt   (meas_cnt),
    .timeout_cnt(timeout_cnt),
`endif
    .coarse_cnt (coarse_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Interval model: k whole periods plus start fine minus stop fine, clamped at zero.
  function automatic int model_interval(input int k, input int fs, input int fp);
    int d;
    d = k * 32 + fs - fp;
    return (d < 0) ? 0 : d;
  endfunction

  // Drives one measurement from ARMED/IDLE through handshake; inputs change on negedges.
  task automatic run_meas(input int fs, input int fp, input int k, input int rdy_delay,
                          input bit arm_after, input bit noisy);
    if (!armed_now) begin
      arm = 1'b1;
      @(negedge clk);
    end
    arm = 1'b1;
    if (noisy) begin
      stop_valid = 1'b1;
      fine_stop  = FINE_W'($urandom_range(0, 31));
      @(negedge clk);
      stop_valid = 1'b1;
    end
    start_valid = 1'b1;
    fine_start  = FINE_W'(fs);
    @(negedge clk);
    start_valid = 1'b0;
    stop_valid  = 1'b0;
    for (int i = 0; i < k; i++) begin
      start_valid = ($urandom_range(0, 3) == 0);
      fine_start  = FINE_W'($urandom_range(0, 31));
      arm         = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start_valid = 1'b0;
    obs_cnt     = int'(coarse_cnt);
    stop_valid  = 1'b1;
    fine_stop   = FINE_W'(fp);
    res_ready   = (rdy_delay == 0);
    @(negedge clk);
    stop_valid = 1'b0;
    fine_stop  = FINE_W'($urandom_range(0, 31));
    obs_lat    = 1;
    while (!res_valid && obs_lat < 8) begin
      @(negedge clk);
      obs_lat++;
    end
    obs_data     = res_data;
    obs_tmo      = res_timeout;
    obs_neg      = res_neg;
    obs_unstable = 0;
    for (int i = 0; i < rdy_delay; i++) begin
      start_valid = 1'($urandom_range(0, 1));
      stop_valid  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!res_valid || res_data !== obs_data || res_timeout !== obs_tmo || res_neg !== obs_neg)
        obs_unstable++;
    end
    start_valid = 1'b0;
    stop_valid  = 1'b0;
    res_ready   = 1'b1;
    arm         = arm_after;
    @(negedge clk);
    res_ready       = 1'b0;
    obs_valid_after = res_valid;
    obs_flags_after = res_timeout | res_neg;
    obs_busy_after  = busy;
    armed_now       = arm_after;
    exp_meas++;
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", res_valid);
    end
    checks++;
    if (res_data !== '0 || res_timeout !== 1'b0 || res_neg !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: got data %0d tmo %b neg %b expected 0 0 0",
               res_data, res_timeout, res_neg);
    end
    checks++;
    if (coarse_cnt !== '0) begin
      errors++; $display("FAIL reset_coarse: got %0d expected 0", coarse_cnt);
    end
  endtask

  task automatic test_basic();
    run_meas(20, 4, 3, 0, 1'b0, 1'b0);
    checks++;
    if (obs_cnt != 3) begin
      errors++; $display("FAIL basic_coarse: got %0d expected 3", obs_cnt);
    end
    checks++;
    if (obs_lat != 2) begin
      errors++; $display("FAIL basic_latency: got %0d expected 2", obs_lat);
    end
    checks++;
    if (obs_data !== DW'(112) || obs_tmo !== 1'b0 || obs_neg !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got %0d tmo %b neg %b expected 112 0 0",
               obs_data, obs_tmo, obs_neg);
    end
    checks++;
    if (obs_valid_after !== 1'b0 || obs_busy_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: got valid %b busy %b expected 0 0",
               obs_valid_after, obs_busy_after);
    end
  endtask

  task automatic test_backpressure();
    run_meas(20, 4, 3, 5, 1'b0, 1'b0);
    checks++;
    if (obs_unstable != 0) begin
      errors++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", obs_unstable);
    end
    checks++;
    if (obs_data !== DW'(112)) begin
      errors++; $display("FAIL hold_data: got %0d expected 112", obs_data);
    end
    checks++;
    if (obs_valid_after !== 1'b0 || obs_busy_after !== 1'b0) begin
      errors++;
      $display("FAIL hold_after: got valid %b busy %b expected 0 0",
               obs_valid_after, obs_busy_after);
    end
  endtask

  task automatic test_negative();
    run_meas(2, 9, 0, 1, 1'b0, 1'b0);
    checks++;
    if (obs_data !== '0 || obs_neg !== 1'b1 || obs_tmo !== 1'b0) begin
      errors++;
      $display("FAIL neg_result: got %0d neg %b tmo %b expected 0 1 0", obs_data, obs_neg, obs_tmo);
    end
    checks++;
    if (obs_flags_after !== 1'b0) begin
      errors++; $display("FAIL neg_flag_clear: got %b expected 0", obs_flags_after);
    end
  endtask

  task automatic test_stray_stops();
    run_meas(7, 3, 6, 1, 1'b0, 1'b1);
    checks++;
    if (obs_data !== DW'(196) || obs_neg !== 1'b0) begin
      errors++; $display("FAIL stray_stop_result: got %0d neg %b expected 196 0", obs_data, obs_neg);
    end
  endtask

  task automatic test_timeout();
    int n;
    arm = 1'b1;
    if (!armed_now) @(negedge clk);
    start_valid = 1'b1;
    fine_start  = FINE_W'($urandom_range(0, 31));
    @(negedge clk);
    start_valid = 1'b0;
    n = 0;
    while (!res_valid && n < TIMEOUT_CYC + 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TIMEOUT_CYC + 1) begin
      errors++; $display("FAIL timeout_latency: got %0d expected %0d", n, TIMEOUT_CYC + 1);
    end
    checks++;
    if (res_data !== 15'h7fff || res_timeout !== 1'b1 || res_neg !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result: got %h tmo %b neg %b expected 7fff 1 0",
               res_data, res_timeout, res_neg);
    end
    checks++;
    if (coarse_cnt !== COARSE_W'(TIMEOUT_CYC)) begin
      errors++; $display("FAIL timeout_coarse: got %0d expected %0d", coarse_cnt, TIMEOUT_CYC);
    end
    res_ready = 1'b1;
    arm       = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    armed_now = 1'b0;
    exp_tmo++;
    checks++;
    if (res_valid !== 1'b0 || res_timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: got valid %b tmo %b busy %b expected 0 0 0",
               res_valid, res_timeout, busy);
    end
  endtask

  task automatic test_stop_at_timeout();
    run_meas(31, 0, TIMEOUT_CYC, 0, 1'b0, 1'b0);
    checks++;
    if (obs_tmo !== 1'b0 || obs_data !== DW'(model_interval(TIMEOUT_CYC, 31, 0))) begin
      errors++;
      $display("FAIL stop_wins: got %0d tmo %b expected %0d 0",
               obs_data, obs_tmo, model_interval(TIMEOUT_CYC, 31, 0));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      run_meas(10 + i, 5, i + 1, i, 1'b1, 1'b0);
      checks++;
      if (obs_data !== DW'(model_interval(i + 1, 10 + i, 5)) || obs_busy_after !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: got %0d busy %b expected %0d 1", i, obs_data, obs_busy_after,
                 model_interval(i + 1, 10 + i, 5));
      end
    end
  endtask

  task automatic test_random();
    int fs, fp, k, exp_d;
    logic exp_n;
    for (int it = 0; it < 40; it++) begin
      fs    = $urandom_range(0, 31);
      fp    = $urandom_range(0, 31);
      k     = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 40);
      exp_n = (k * 32 + fs - fp) < 0;
      exp_d = model_interval(k, fs, fp);
      run_meas(fs, fp, k, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0));
      checks++;
      if (obs_data !== DW'(exp_d) || obs_neg !== exp_n || obs_tmo !== 1'b0 || obs_lat != 2 ||
          obs_unstable != 0 || obs_valid_after !== 1'b0 || obs_busy_after !== armed_now) begin
        errors++;
        $display("FAIL random_%0d: got data %0d neg %b tmo %b lat %0d unst %0d busy %b expected %0d %b 0 2 0 %b",
                 it, obs_data, obs_neg, obs_tmo, obs_lat, obs_unstable, obs_busy_after,
                 exp_d, exp_n, armed_now);
      end
    end
  endtask

  task automatic test_async_reset();
`ifdef TDC_MEAS_STATS_EN
    checks++;
    if (meas_cnt !== 16'(exp_meas) || timeout_cnt !== 8'(exp_tmo)) begin
      errors++;
      $display("FAIL stats_before_reset: got %0d %0d expected %0d %0d",
               meas_cnt, timeout_cnt, exp_meas, exp_tmo);
    end
`endif
    arm = 1'b1;
    if (!armed_now) @(negedge clk);
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (50) @(negedge clk);
    checks++;
    if (coarse_cnt !== COARSE_W'(50)) begin
      errors++; $display("FAIL reset_mid_coarse: got %0d expected 50", coarse_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || coarse_cnt !== '0 || res_data !== '0 ||
        res_timeout !== 1'b0 || res_neg !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got busy %b valid %b coarse %0d data %0d expected all 0",
               busy, res_valid, coarse_cnt, res_data);
    end
    arm = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    armed_now = 1'b0;
    exp_meas  = 0;
    exp_tmo   = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: got busy %b expected 0", busy);
    end
`ifdef TDC_MEAS_STATS_EN
    checks++;
    if (meas_cnt !== 16'd0 || timeout_cnt !== 8'd0) begin
      errors++; $display("FAIL stats_reset: got %0d %0d expected 0 0", meas_cnt, timeout_cnt);
    end
    for (int i = 0; i < 3; i++) run_meas(5, 1, 2, 0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (meas_cnt !== 16'd3 || timeout_cnt !== 8'd0) begin
      errors++; $display("FAIL stats_count: got %0d %0d expected 3 0", meas_cnt, timeout_cnt);
    end
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    arm         = 1'b0;
    start_valid = 1'b0;
    stop_valid  = 1'b0;
    fine_start  = '0;
    fine_stop   = '0;
    res_ready   = 1'b0;
    armed_now   = 1'b0;
    exp_meas    = 0;
    exp_tmo     = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_negative();
    test_stray_stops();
    test_back_to_back();
    test_timeout();
    test_stop_at_timeout();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Measurement sequencer for the start/stop TDC channel pair. Arms the channel and counts whole clock periods between the filtered start and stop valids. Captures the 5-bit fine codes from the start and stop thermometer encoders and combines coarse and fine into one interval word. Presents that word on a valid/ready result port to the readout logic. Sits between the input/stop filters plus encoders and the readout FIFO, and replaces the standalone coarse counter.

Parameters:
COARSE_W, 10, coarse counter width in bits
FINE_W, 5, fine code width in bits (32 bins per clock period)
TIMEOUT_CYC, 1000, coarse count at which a pending measurement is aborted; must be < 2**COARSE_W

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
arm  in  1  level; 1 = accept a new measurement when IDLE
start_valid  in  1  one-cycle pulse from the input filter
stop_valid  in  1  one-cycle pulse from the stop filter
fine_start  in  FINE_W  start encoder code; valid in the cycle start_valid=1
fine_stop  in  FINE_W  stop encoder code; valid in the cycle stop_valid=1
res_ready  in  1  readout accepts the result
res_valid  out  1  result available
res_data  out  COARSE_W+FINE_W  interval in fine bins
res_timeout  out  1  qualifies res_data: no stop arrived before TIMEOUT_CYC
res_neg  out  1  qualifies res_data: computed interval was negative and is clamped to 0
busy  out  1  1 in any state other than IDLE
coarse_cnt  out  COARSE_W  live coarse counter, for debug

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, res_valid, res_timeout and res_neg are 0; res_data and coarse_cnt are 0; captured fine codes are 0.
- States: IDLE, ARMED, COUNT, CALC, OUT.
- IDLE -> ARMED when arm=1. Takes one cycle. start_valid and stop_valid are ignored in IDLE.
- ARMED: on start_valid=1, latch fine_start, clear coarse_cnt to 0, go to COUNT. stop_valid without start_valid is ignored.
- ARMED with start_valid=1 and stop_valid=1 in the same cycle: treat as start only. Stop is ignored.
- COUNT: coarse_cnt increments by 1 each cycle.
  - On stop_valid=1, latch fine_stop, freeze coarse_cnt at its value in that cycle (no increment), go to CALC.
  - Further start_valid pulses are ignored.
  - If coarse_cnt == TIMEOUT_CYC with no stop: set res_timeout=1, set res_data = all ones, go to OUT. CALC is skipped.
  - A stop arriving in the same cycle as the timeout wins: the measurement is normal.
- CALC takes one cycle.
  - Compute D = coarse_cnt*2**FINE_W + fine_start - fine_stop as a signed value of width COARSE_W+FINE_W+1.
  - If D < 0: res_data=0 and res_neg=1. Otherwise res_data = D[COARSE_W+FINE_W-1:0] and res_neg=0.
  - Go to OUT.
- OUT: res_valid=1. res_data, res_timeout and res_neg stay stable until handshake.
  - Handshake is the cycle with res_valid & res_ready.
  - In the cycle after the handshake: res_valid=0 and the flags clear.
  - Next state is ARMED if arm=1 in the handshake cycle, else IDLE.
  - Hits during OUT are dropped.
- Latency: from stop_valid to res_valid is 2 cycles (stop edge -> CALC -> OUT). res_valid may be asserted with res_ready already high; the transfer then completes in that first OUT cycle.
- arm deasserted in ARMED: return to IDLE next cycle. arm deasserted in COUNT, CALC or OUT: the measurement in flight completes.
- Asserting rst_n=0 in any state aborts immediately. Any pending result is lost.

Optional Feature:
Macro TDC_MEAS_STATS_EN.
- When defined, add output meas_cnt (16 bits) and output timeout_cnt (8 bits).
- meas_cnt increments on every handshake of a non-timeout result.
- timeout_cnt increments on every timeout handshake.
- Both counters wrap modulo their width and reset to 0.
- When undefined, both ports and the counters are absent. Behaviour is otherwise identical.

Test Plan:
1. Reset, arm=1, start_valid with fine_start=20, stop_valid 3 cycles later with fine_stop=4, res_ready=1 -> res_valid 2 cycles after stop, res_data=3*32+20-4=112, res_timeout=0, res_neg=0.
2. Same as 1 but res_ready=0 for 5 cycles -> res_valid and res_data=112 held stable for 5 cycles; transfer on the first cycle res_ready=1; busy=0 next cycle if arm=0.
3. Start, then no stop -> at coarse_cnt=1000: res_valid=1, res_timeout=1, res_data=0x7FFF.
4. stop_valid in the cycle after start (coarse_cnt=0), fine_start=2, fine_stop=9 -> res_data=0, res_neg=1.
5. stop_valid before start while ARMED, then simultaneous start and stop -> both stops ignored; measurement ends only on a later stop.
6. rst_n pulsed low mid-COUNT with coarse_cnt=50 -> all outputs 0 and state IDLE asynchronously; with TDC_MEAS_STATS_EN defined, meas_cnt=0 after reset and equals 3 after three good handshakes.
